cas_block_ctrl: RTL

CAS_BLOCK_CTRL -- requirements
Module: cas_block_ctrl

---
 rtl/cas_pkg.sv | 11 +
 rtl/cas_block_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cas_pkg.sv
// Shared constants and state encoding for the cassette block controller.
package cas_pkg;
  localparam logic [7:0] CAS_LEADER_BYTE = 8'h55;
  localparam logic [7:0] CAS_SYNC_BYTE   = 8'h3C;

  typedef enum logic [3:0] {
    IDLE, LEADER, SYNC, TYPE, LEN, FETCH, DATA, CSUM, TRAIL, GAP
  } cas_state_e;

  typedef enum logic {SEND, WAIT} cas_phase_e;
endpackage

// File: rtl/cas_block_ctrl.sv
// Cassette block framer: leader, sync, type, len, data, checksum, trailer fed bytewise to a serializer.
// Define CAS_GAP_EN to hold busy for GAP_CYCLES of silence after each completed block.
module cas_block_ctrl
  import cas_pkg::*;
#(
  parameter int          LEADER_LEN = 128,
  parameter logic [23:0] GAP_CYCLES = 24'd500000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       blk_req,
  input  logic [7:0] blk_type,
  input  logic [7:0] blk_len,
  input  logic       abort,
  output logic       byte_rd,
  output logic [7:0] byte_addr,
  input  logic [7:0] byte_in,
  output logic       sq_start,
  output logic [7:0] sq_din,
  input  logic       sq_done,
  output logic       busy,
  output logic       blk_done,
  output logic [7:0] csum
);

  // One counter serves both the leader run and the post-block gap.
  localparam int CW = $bits(GAP_CYCLES);

  cas_state_e    state, state_n;
  cas_phase_e    ph, ph_n;
  logic          wfirst, wfirst_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]    idx, idx_n, type_r, type_n, len_r, len_n, csum_r, csum_n, din_q;
  logic          done_q, done_n, abort_r, abort_n;
  logic          byte_fin, stop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      ph      <= SEND;
      wfirst  <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
      type_r  <= '0;
      len_r   <= '0;
      csum_r  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      state   <= state_n;
      ph      <= ph_n;
      wfirst  <= wfirst_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      type_r  <= type_n;
      len_r   <= len_n;
      csum_r  <= csum_n;
      din_q   <= sq_din;
      done_q  <= done_n;
      abort_r <= abort_n;
    end
  end

  assign busy      = (state != IDLE);
  assign blk_done  = done_q;
  assign csum      = csum_r;
  assign byte_addr = idx;

  // sq_done is stale during the first WAIT cycle, so it only counts afterwards.
  assign byte_fin = (ph == WAIT) && !wfirst && sq_done;
  assign stop     = abort_r | abort;

  always_comb begin
    state_n  = state;
    ph_n     = ph;
    wfirst_n = 1'b0;
    cnt_n    = cnt;
    idx_n    = idx;
    type_n   = type_r;
    len_n    = len_r;
    csum_n   = csum_r;
    done_n   = 1'b0;
    abort_n  = abort_r | (abort & busy);
    sq_start = 1'b0;
    sq_din   = din_q;
    byte_rd  = 1'b0;
    case (state)
      IDLE: begin
        // A request coinciding with blk_done belongs to the finishing block's window.
        if (blk_req && !done_q) begin
          type_n  = blk_type;
          len_n   = blk_len;
          csum_n  = '0;
          cnt_n   = '0;
          idx_n   = '0;
          abort_n = 1'b0;
          ph_n    = SEND;
          state_n = (LEADER_LEN == 0) ? SYNC : LEADER;
        end
      end
      FETCH: begin
        byte_rd = 1'b1;
        ph_n    = SEND;
        state_n = DATA;
      end
`ifdef CAS_GAP_EN
      GAP: begin
        if (cnt == GAP_CYCLES) state_n = IDLE;
        else                   cnt_n   = cnt + CW'(1);
      end
`endif
      LEADER, SYNC, TYPE, LEN, DATA, CSUM, TRAIL: begin
        if (ph == SEND) begin
          sq_start = 1'b1;
          ph_n     = WAIT;
          wfirst_n = 1'b1;
          case (state)
            SYNC: sq_din = CAS_SYNC_BYTE;
            TYPE: begin sq_din = type_r;  csum_n = csum_r + type_r;  end
            LEN:  begin sq_din = len_r;   csum_n = csum_r + len_r;   end
            DATA: begin sq_din = byte_in; csum_n = csum_r + byte_in; end
            CSUM: sq_din = csum_r;
            default: sq_din = CAS_LEADER_BYTE;
          endcase
        end else if (byte_fin) begin
          ph_n = SEND;
          if (stop) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            case (state)
              LEADER: begin
                if (cnt == CW'(LEADER_LEN - 1)) begin
                  cnt_n   = '0;
                  state_n = SYNC;
                end else begin
                  cnt_n = cnt + CW'(1);
                end
              end
              SYNC: state_n = TYPE;
              TYPE: state_n = LEN;
              LEN:  state_n = (len_r == 8'd0) ? CSUM : FETCH;
              DATA: begin
                if (idx + 8'd1 == len_r) state_n = CSUM;
                else begin
                  idx_n   = idx + 8'd1;
                  state_n = FETCH;
                end
              end
              CSUM: state_n = TRAIL;
              default: begin
                done_n = 1'b1;
`ifdef CAS_GAP_EN
                cnt_n   = '0;
                state_n = GAP;
`else
                state_n = IDLE;
`endif
              end
            endcase
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
